// File: rtl/dmem_arbiter_if.sv
// One master port of the data-memory arbiter: request/command from the master,
// grant and registered read return from the arbiter.
interface dmem_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              req;
   logic              we;
   logic              lock;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, lock, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, lock, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of a single-port data memory: one access per cycle,
// round-robin or fixed priority, bounded locked bursts, registered read return.
module dmem_arbiter #(
   parameter int PRIO_MODE = 0,
   parameter int MAX_LOCK  = 8,
   parameter int CNT_W     = 4,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   dmem_arbiter_if.slave     m0,
   dmem_arbiter_if.slave     m1,
   output logic              mem_W_en,
   output logic              mem_R_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

   state_t            state;
   logic              last_gnt;
   logic [CNT_W-1:0]  lock_cnt;
   logic              release_pend;

   logic              gnt0;
   logic              gnt1;
   logic              granted;
   logic              sel_we;
   logic              sel_lock;
   logic [CNT_W-1:0]  lock_next;

   logic              rvld0_p1;
   logic              rvld1_p1;
   logic [DATA_W-1:0] rdata0_p1;
   logic [DATA_W-1:0] rdata1_p1;

   // Grant decision is combinational so the memory sees the access in the same cycle.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         unique case (state)
            IDLE: begin
               if (m0.req && m1.req) begin
                  // A forced release overrides fixed priority once, so the waiting port gets in.
                  if (PRIO_MODE == 1 && !release_pend) gnt0 = 1'b1;
                  else if (last_gnt)                   gnt0 = 1'b1;
                  else                                 gnt1 = 1'b1;
               end else begin
                  gnt0 = m0.req;
                  gnt1 = m1.req;
               end
            end
            LOCK0:   gnt0 = m0.req;
            LOCK1:   gnt1 = m1.req;
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_addr = '0;
      mem_din  = '0;
      sel_we   = 1'b0;
      sel_lock = 1'b0;
      if (gnt0) begin
         mem_addr = m0.addr;
         mem_din  = m0.wdata;
         sel_we   = m0.we;
         sel_lock = m0.lock;
      end else if (gnt1) begin
         mem_addr = m1.addr;
         mem_din  = m1.wdata;
         sel_we   = m1.we;
         sel_lock = m1.lock;
      end
   end

   assign granted   = gnt0 | gnt1;
   assign mem_W_en  = granted & sel_we;
   assign mem_R_en  = granted & ~sel_we;
   assign lock_next = lock_cnt + CNT_W'(1);

   assign m0.gnt    = gnt0;
   assign m1.gnt    = gnt1;
   assign m0.rvalid = rvld0_p1;
   assign m1.rvalid = rvld1_p1;
   assign m0.rdata  = rdata0_p1;
   assign m1.rdata  = rdata1_p1;

   // ---- stage p1: read return registers and arbitration state ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         last_gnt     <= 1'b1;
         lock_cnt     <= '0;
         release_pend <= 1'b0;
         rvld0_p1     <= 1'b0;
         rvld1_p1     <= 1'b0;
         rdata0_p1    <= '0;
         rdata1_p1    <= '0;
      end else begin
         rvld0_p1 <= gnt0 & ~m0.we;
         rvld1_p1 <= gnt1 & ~m1.we;
         if (gnt0 && !m0.we) rdata0_p1 <= mem_dout;
         if (gnt1 && !m1.we) rdata1_p1 <= mem_dout;
         if (granted) last_gnt <= gnt1;

         unique case (state)
            IDLE: begin
               if (granted) begin
                  release_pend <= 1'b0;
                  if (sel_lock) begin
                     state    <= gnt1 ? LOCK1 : LOCK0;
                     lock_cnt <= CNT_W'(1);
                  end
               end
            end
            default: begin
               if (!granted) begin
                  state    <= IDLE;
                  lock_cnt <= '0;
               end else if (lock_next == CNT_W'(MAX_LOCK)) begin
                  state        <= IDLE;
                  lock_cnt     <= '0;
                  release_pend <= 1'b1;
               end else if (!sel_lock) begin
                  state    <= IDLE;
                  lock_cnt <= '0;
               end else begin
                  lock_cnt <= lock_next;
               end
            end
         endcase
      end
   end

endmodule
